// File: rtl/wb_merge_if.sv
// wb_merge_if: bundles the EX/LSU result inputs and the register-file write
// port of wb_merge.
// Handshake: the load channel moves a beat on every clk edge where
// ld_valid && ld_ready are both 1. ld_ready depends only on registered state.
// The ALU channel has no ready: an alu_valid beat is always consumed.
interface wb_merge_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        w_regs_en;
  logic [4:0]  w_regs_addr;
  logic [31:0] w_regs_data;
  logic [31:0] pend_mask;

  // Upstream side (EX/LSU driver) and consumer of the write port.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
    input  ld_ready,
    input  w_regs_en, w_regs_addr, w_regs_data, pend_mask
  );

  // The writeback merge block itself.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
    output ld_ready,
    output w_regs_en, w_regs_addr, w_regs_data, pend_mask
  );
endinterface

// File: rtl/wb_merge.sv
// wb_merge: merges single-cycle ALU results with formatted load results into
// one registered register-file write per cycle. Loads wait in a DEPTH-entry
// FIFO; ALU results always take priority and kill older buffered loads to the
// same register.
// Optional macro WB_SCOREBOARD_EN builds pend_mask (loads accepted but not
// yet written); without it pend_mask is tied to zero.
module wb_merge #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  wb_merge_if.slave  bus
);

  // FIFO storage: live flag, destination and formatted data per entry.
  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [31:0]      dat_q  [DEPTH];
  logic [31:0]      dat_d  [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  // Registered write port.
  logic             w_en_q, w_en_d;
  logic [4:0]       w_addr_q, w_addr_d;
  logic [31:0]      w_data_q, w_data_d;

  logic             push;
  logic             pop;
  logic             kill;
  logic [31:0]      ld_fmt;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic             head_live;
  logic [4:0]       head_rd;
  logic [31:0]      head_data;

  assign bus.ld_ready = (count_q != (AW+1)'(DEPTH));
  assign push         = bus.ld_valid && bus.ld_ready;
  assign pop          = !bus.alu_valid && (count_q != '0);
  assign kill         = bus.alu_valid && (bus.alu_rd != 5'd0);
  assign head_live    = live_q[rd_ptr_q];
  assign head_rd      = rd_q[rd_ptr_q];
  assign head_data    = dat_q[rd_ptr_q];

  // Extract the addressed byte/half and extend it before it enters the FIFO.
  always_comb begin
    ld_byte = 8'(bus.ld_data >> {bus.ld_addr_lo, 3'b000});
    ld_half = 16'(bus.ld_data >> {bus.ld_addr_lo[1], 4'b0000});
    case (bus.ld_funct3)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'd0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'd0, ld_half};
      default: ld_fmt = bus.ld_data;
    endcase
  end

  // FIFO next state: kill matching older entries, then push, advance pointers.
  always_comb begin
    live_d   = live_q;
    rd_d     = rd_q;
    dat_d    = dat_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    // Free slots may be cleared too; a push always re-sets live.
    for (int i = 0; i < DEPTH; i++) begin
      if (kill && (rd_q[i] == bus.alu_rd)) live_d[i] = 1'b0;
    end
    if (push) begin
      live_d[wr_ptr_q] = 1'b1;
      rd_d[wr_ptr_q]   = bus.ld_rd;
      dat_d[wr_ptr_q]  = ld_fmt;
      wr_ptr_d         = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  // Write port select: ALU first, else a live FIFO head; rd=0 never writes.
  always_comb begin
    w_en_d   = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (bus.alu_valid) begin
      if (bus.alu_rd != 5'd0) begin
        w_en_d   = 1'b1;
        w_addr_d = bus.alu_rd;
        w_data_d = bus.alu_data;
      end
    end else if (pop && head_live && (head_rd != 5'd0)) begin
      w_en_d   = 1'b1;
      w_addr_d = head_rd;
      w_data_d = head_data;
    end
  end

  // Control state and write port registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      live_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= 5'd0;
      w_data_q <= 32'd0;
    end else begin
      live_q   <= live_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  // Entry payload needs no reset: it is only read while live/occupied.
  always_ff @(posedge clk) begin
    rd_q  <= rd_d;
    dat_q <= dat_d;
  end

  assign bus.w_regs_en   = w_en_q;
  assign bus.w_regs_addr = w_addr_q;
  assign bus.w_regs_data = w_data_q;

`ifdef WB_SCOREBOARD_EN
  logic [31:0]      pend_q, pend_d;
  logic [DEPTH-1:0] occ;
  logic             other_live;

  // Mark which slots currently hold buffered entries.
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ[i] = ({1'b0, AW'(AW'(i) - rd_ptr_q)} < count_q);
    end
  end

  // Another live entry for the head's rd keeps its pending bit set on pop.
  always_comb begin
    other_live = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i] && live_q[i] && (rd_q[i] == head_rd) && (AW'(i) != rd_ptr_q))
        other_live = 1'b1;
    end
  end

  // Pending mask update; a same-cycle set overrides any clear.
  always_comb begin
    pend_d = pend_q;
    if (pop && head_live && !other_live) pend_d[head_rd] = 1'b0;
    if (kill) pend_d[bus.alu_rd] = 1'b0;
    if (push && (bus.ld_rd != 5'd0)) pend_d[bus.ld_rd] = 1'b1;
  end

  // Pending mask register.
  always_ff @(posedge clk) begin
    if (rst) pend_q <= 32'd0;
    else     pend_q <= pend_d;
  end

  assign bus.pend_mask = pend_q;
`else
  assign bus.pend_mask = 32'd0;
`endif

endmodule

// File: doc/wb_merge.md
Name: wb_merge

Overview:
- Writeback-side producer for the register-file write port.
- Merges single-cycle ALU results with load results returning from the LSU, and drives one registered write per cycle: w_regs_en / w_regs_addr / w_regs_data.
- Load data is byte/half extracted and sign/zero extended here, then buffered in a small FIFO so that ALU writebacks never stall.
- Sits between the EX/LSU outputs and the register file.

Parameters:
- DEPTH, 4, load buffer entries; power of 2, minimum 2.
- AW, 2, log2(DEPTH); FIFO pointer width.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous reset, active-high
- alu_valid  input  1  ALU result present this cycle; no backpressure
- alu_rd  input  5  ALU destination register
- alu_data  input  32  ALU result
- ld_valid  input  1  load response valid
- ld_ready  output  1  load response accepted when ld_valid && ld_ready
- ld_rd  input  5  load destination register
- ld_data  input  32  raw aligned memory word
- ld_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ld_addr_lo  input  2  byte offset of the load address
- w_regs_en  output  1  register-file write enable
- w_regs_addr  output  5  register-file write address
- w_regs_data  output  32  register-file write data
- pend_mask  output  32  bit n set = load to xn accepted, not yet written

Behaviour:
- Reset (rst=1 at a clk edge): w_regs_en=0, w_regs_addr=0, w_regs_data=0, FIFO empty (count=0, pointers 0), pend_mask=0, ld_ready=1 on the following cycle. Reset mid-operation discards all buffered loads.
- ld_ready = (count != DEPTH), derived from registered count only; no combinational path from ld_valid.
- Load formatting is combinational, before the FIFO push:
  - LB/LBU: byte ld_data[8*ld_addr_lo +: 8].
  - LH/LHU: half ld_data[16*ld_addr_lo[1] +: 16]; ld_addr_lo[0] is ignored.
  - LW and any other funct3: full word.
  - Signed types sign-extend to 32 bits; unsigned types zero-extend.
- Each FIFO entry holds {live, rd, data32}. live=1 on push.
- Output select each cycle (result registered on next edge):
  - alu_valid=1: write ALU result; FIFO holds.
  - else FIFO non-empty: pop head; write it if head.live=1, otherwise drop it and keep w_regs_en=0.
  - else: w_regs_en=0.
  - w_regs_addr/w_regs_data hold their last value when w_regs_en=0.
- rd=0 writes from either source are consumed but produce w_regs_en=0.
- Latency:
  - ALU: 1 cycle, result lands on the next edge.
  - Load: minimum 2 cycles (push edge, then pop edge).
- Ordering kill: when alu_valid with alu_rd!=0, clear live on every buffered entry whose rd equals alu_rd (the buffered load is older, so the ALU write wins). An entry pushed in the same cycle is not killed.
- Simultaneous push and pop: count unchanged; legal when full because ld_ready is already 0.
- Pointer wrap: pointers are AW-bit and wrap modulo DEPTH; count is AW+1 bits.
- Continuous alu_valid starves the FIFO: once full, ld_ready stays 0. This is legal; the upstream LSU holds its response.

Optional Feature:
- Macro: WB_SCOREBOARD_EN.
- Defined:
  - pend_mask[rd] is set on load accept with rd!=0.
  - The bit is cleared on pop of the last live entry for that rd, or on a kill of that rd.
  - If set and clear hit the same rd in one cycle, set wins.
  - Issue logic uses pend_mask to stall on load-use.
- Not defined: pend_mask is constant 0 and no scoreboard flops are built.

Test Plan:
- ALU only: alu_valid, rd=5, data=0x1234_5678 -> next cycle w_regs_en=1, addr=5, data=0x12345678.
- Load formatting, ld_data=0x80F0_7F81:
  - LB off 0 -> 0xFFFFFF81
  - LBU off 3 -> 0x00000080
  - LH off 2 -> 0xFFFF80F0
  - LHU off 0 -> 0x00007F81
  - Each written 2 cycles after accept.
- Collision: load rd=3 accepted, then alu_valid rd=4 for 3 cycles -> x4 written 3 times, then x3 written the cycle after alu_valid drops.
- Full: hold alu_valid, push 4 loads -> ld_ready=0 after the 4th; 5th ld_valid is not accepted; drop alu_valid -> 4 writes in FIFO order, ld_ready=1 after the first pop.
- Kill: load rd=7 buffered, alu_valid rd=7 data=0xA -> x7=0xA written; popped load entry gives w_regs_en=0; pend_mask[7] clears (WB_SCOREBOARD_EN).
- rd=0 and reset: load rd=0 gives no write enable; assert rst with 2 entries buffered -> no writes afterward, pend_mask=0, ld_ready=1.
